// File: rtl/x_shift_reg_cfg.sv
// Parametrised multi-lane shift register with clock enable, direction, parallel load and fill counter.
// Optional rotate mode (i_rot port and logic) is built only when X_SHIFT_ROTATE_EN is defined.
module x_shift_reg_cfg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_dir,
  input  logic [WIDTH-1:0]       i_in,
  input  logic                   i_load,
  input  logic [WIDTH*DEPTH-1:0] i_data,
`ifdef X_SHIFT_ROTATE_EN
  input  logic                   i_rot,
`endif
  output logic [WIDTH*DEPTH-1:0] o_data,
  output logic [WIDTH-1:0]       o_msb,
  output logic [WIDTH-1:0]       o_lsb,
  output logic [CW-1:0]          o_count,
  output logic                   o_full
);

  logic [WIDTH-1:0] stage_reg  [DEPTH];
  logic [WIDTH-1:0] stage_next [DEPTH];
  logic [WIDTH-1:0] up_src     [DEPTH];
  logic [WIDTH-1:0] dn_src     [DEPTH];
  logic [CW-1:0]    count_reg, count_next;
  logic             full_reg;
  logic             rot_en;

`ifdef X_SHIFT_ROTATE_EN
  assign rot_en = i_rot;
`else
  assign rot_en = 1'b0;
`endif

  // End stages take i_in on a shift, or the opposite end stage on a rotate.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_up_first
      assign up_src[gi] = rot_en ? stage_reg[DEPTH-1] : i_in;
    end else begin : g_up_rest
      assign up_src[gi] = stage_reg[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_dn_last
      assign dn_src[gi] = rot_en ? stage_reg[0] : i_in;
    end else begin : g_dn_rest
      assign dn_src[gi] = stage_reg[gi+1];
    end

    assign stage_next[gi] = i_load ? i_data[gi*WIDTH +: WIDTH] :
                            i_en   ? (i_dir ? dn_src[gi] : up_src[gi]) :
                                     stage_reg[gi];

    assign o_data[gi*WIDTH +: WIDTH] = stage_reg[gi];
  end

  always_comb begin
    count_next = count_reg;
    if (i_load) begin
      count_next = CW'(DEPTH);
    end else if (i_en && !rot_en && (count_reg != CW'(DEPTH))) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
      count_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      stage_reg <= stage_next;
      count_reg <= count_next;
      // Count only moves up or reloads to DEPTH, so full is sticky until reset.
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  assign o_msb   = stage_reg[DEPTH-1];
  assign o_lsb   = stage_reg[0];
  assign o_count = count_reg;
  assign o_full  = full_reg;

endmodule

// File: tb/tb_x_shift_reg_cfg.sv
// Self-checking bench for x_shift_reg_cfg: legacy 1x32 instance plus an 8x4 instance driven
// by directed cases and random stimulus against a queue-based reference model.
module tb_x_shift_reg_cfg;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Legacy instance: WIDTH=1, DEPTH=32
  logic        a_rst = 1'b1, a_en = 1'b1, a_dir = 1'b0, a_load = 1'b0;
  logic [0:0]  a_in = 1'b0;
  logic [31:0] a_data = '0;
  logic [31:0] a_odata;
  logic [0:0]  a_msb, a_lsb;
  logic [5:0]  a_count;
  logic        a_full;
  logic        a_rot = 1'b0;

  x_shift_reg_cfg #(.WIDTH(1), .DEPTH(32)) u_a (
    .i_clk(i_clk), .i_rst(a_rst), .i_en(a_en), .i_dir(a_dir), .i_in(a_in),
    .i_load(a_load), .i_data(a_data),
`ifdef X_SHIFT_ROTATE_EN
    .i_rot(a_rot),
`endif
    .o_data(a_odata), .o_msb(a_msb), .o_lsb(a_lsb), .o_count(a_count), .o_full(a_full)
  );

  // Lane instance: WIDTH=8, DEPTH=4
  logic        b_rst = 1'b1, b_en = 1'b0, b_dir = 1'b0, b_load = 1'b0, b_rot = 1'b0;
  logic [7:0]  b_in = '0;
  logic [31:0] b_data = '0;
  logic [31:0] b_odata;
  logic [7:0]  b_msb, b_lsb;
  logic [2:0]  b_count;
  logic        b_full;

  x_shift_reg_cfg #(.WIDTH(8), .DEPTH(4)) u_b (
    .i_clk(i_clk), .i_rst(b_rst), .i_en(b_en), .i_dir(b_dir), .i_in(b_in),
    .i_load(b_load), .i_data(b_data),
`ifdef X_SHIFT_ROTATE_EN
    .i_rot(b_rot),
`endif
    .o_data(b_odata), .o_msb(b_msb), .o_lsb(b_lsb), .o_count(b_count), .o_full(b_full)
  );

  // Reference model for the 8x4 instance: queue index k is stage k.
  logic [7:0] mq[$];
  int         mcnt;

  function automatic logic [31:0] model_pack();
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = mq[k];
    return r;
  endfunction

  task automatic model_apply(input bit rst, load, en, dir, rot, input logic [7:0] din,
                             input logic [31:0] ld);
    logic [7:0] t;
    if (rst) begin
      mq = '{8'h0, 8'h0, 8'h0, 8'h0};
      mcnt = 0;
    end else if (load) begin
      for (int k = 0; k < 4; k++) mq[k] = ld[k*8 +: 8];
      mcnt = 4;
    end else if (en) begin
`ifdef X_SHIFT_ROTATE_EN
      if (rot) begin
        if (!dir) begin t = mq.pop_back();  mq.push_front(t); end
        else      begin t = mq.pop_front(); mq.push_back(t);  end
      end else
`endif
      begin
        if (!dir) begin mq.push_front(din); t = mq.pop_back();  end
        else      begin mq.push_back(din);  t = mq.pop_front(); end
        mcnt = (mcnt < 4) ? mcnt + 1 : 4;
      end
    end
  endtask

  task automatic step_b(input bit rst, load, en, dir, rot, input logic [7:0] din,
                        input logic [31:0] ld);
    b_rst = rst; b_load = load; b_en = en; b_dir = dir; b_rot = rot; b_in = din; b_data = ld;
    @(posedge i_clk);
    model_apply(rst, load, en, dir, rot, din, ld);
    #1;
    check_eq("b_data",  b_odata, model_pack());
    check_eq("b_msb",   b_msb,   mq[3]);
    check_eq("b_lsb",   b_lsb,   mq[0]);
    check_eq("b_count", b_count, mcnt);
    check_eq("b_full",  b_full,  mcnt == 4);
    $display("b rst=%0b ld=%0b en=%0b dir=%0b rot=%0b in=%02h -> data=%08h cnt=%0d full=%0b",
             rst, load, en, dir, rot, din, b_odata, b_count, b_full);
  endtask

  initial begin
    mq = '{8'h0, 8'h0, 8'h0, 8'h0};
    mcnt = 0;

    // Legacy equivalence: reset 2 cycles, single 1 pulse, watch it emerge after 32 edges.
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("a_rst_data",  a_odata, 32'h0);
    check_eq("a_rst_count", a_count, 0);
    check_eq("a_rst_full",  a_full,  1'b0);
    a_rst = 1'b0;
    a_in  = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge i_clk);
      #1;
      a_in = 1'b0;
      check_eq("a_msb",   a_msb,   (n == 32) ? 1'b1 : 1'b0);
      check_eq("a_count", a_count, (n < 32) ? n : 32);
      check_eq("a_full",  a_full,  (n >= 32) ? 1'b1 : 1'b0);
      $display("a shift %0d -> msb=%0b cnt=%0d full=%0b", n, a_msb, a_count, a_full);
    end

    // Mid-stream reset on the 32-deep instance.
    a_rst = 1'b1;
    @(posedge i_clk);
    #1;
    a_rst = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      a_in = 1'($urandom);
      @(posedge i_clk);
      #1;
    end
    check_eq("a_ten_count", a_count, 10);
    a_rst = 1'b1;
    @(posedge i_clk);
    #1;
    a_rst = 1'b0;
    check_eq("a_mid_rst_data",  a_odata, 32'h0);
    check_eq("a_mid_rst_count", a_count, 0);
    a_in = 1'b1;
    @(posedge i_clk);
    #1;
    a_en = 1'b0;
    check_eq("a_post_rst_count", a_count, 1);
    check_eq("a_post_rst_lsb",   a_lsb,   1'b1);
    $display("a mid-stream reset -> cnt=%0d", a_count);

    // Reset state of the lane instance.
    step_b(1, 0, 0, 0, 0, 8'h00, 32'h0);
    check_eq("b_rst_data", b_odata, 32'h0);

    // Stall: two shifts, five idle cycles, two more shifts.
    step_b(0, 0, 1, 0, 0, 8'h11, 32'h0);
    step_b(0, 0, 1, 0, 0, 8'h22, 32'h0);
    for (int n = 0; n < 5; n++) begin
      step_b(0, 0, 0, 0, 0, 8'($urandom), 32'h0);
      check_eq("b_stall_count", b_count, 2);
    end
    step_b(0, 0, 1, 0, 0, 8'h33, 32'h0);
    step_b(0, 0, 1, 0, 0, 8'h44, 32'h0);
    check_eq("b_stall_image", b_odata, 32'h1122_3344);

    // Load then drain downward.
    step_b(1, 0, 0, 0, 0, 8'h00, 32'h0);
    step_b(0, 1, 1, 1, 0, 8'hFF, 32'hA3A2_A1A0);
    check_eq("b_load_lsb",  b_lsb,  8'hA0);
    check_eq("b_load_full", b_full, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      step_b(0, 0, 1, 1, 0, 8'hFF, 32'h0);
      check_eq("b_drain_lsb", b_lsb, (n < 4) ? 8'(8'hA0 + n) : 8'hFF);
    end

    // Priority: reset beats load and enable; load beats enable.
    step_b(1, 1, 1, 0, 0, 8'h5A, 32'hDEAD_BEEF);
    check_eq("b_prio_rst_data",  b_odata, 32'h0);
    check_eq("b_prio_rst_count", b_count, 0);
    step_b(0, 1, 1, 0, 0, 8'h5A, 32'hCAFE_F00D);
    check_eq("b_prio_load_data", b_odata, 32'hCAFE_F00D);

`ifdef X_SHIFT_ROTATE_EN
    // Rotate up keeps the count and ignores i_in.
    step_b(0, 1, 0, 0, 0, 8'h00, 32'h0302_0100);
    step_b(0, 0, 1, 0, 1, 8'h55, 32'h0);
    check_eq("b_rot_image", b_odata, 32'h0201_0003);
    check_eq("b_rot_count", b_count, 4);
`endif

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step_b(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) < 7), 1'($urandom),
`ifdef X_SHIFT_ROTATE_EN
             ($urandom_range(0, 3) == 0),
`else
             1'b0,
`endif
             8'($urandom), 32'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
